// File: rtl/decimal_counter_pkg.sv
// Shared types and constants for the multi-digit BCD counter.
// Optional build macro: DECIMAL_COUNTER_DOWN_EN (adds down-counting).
package decimal_counter_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Next value of one digit, wrapping 9->0 going up and 0->9 going down.
   function automatic logic [BCD_W-1:0] bcdStep(input logic [BCD_W-1:0] val, input logic down);
      if (down)
         return (val == '0) ? BCD_MAX : val - 4'd1;
      else
         return (val == BCD_MAX) ? '0 : val + 4'd1;
   endfunction

endpackage

// File: rtl/decimal_counter_core_if.sv
// Control/status bundle between the divider chain, the counter and the display stage.
// Optional build macro: DECIMAL_COUNTER_DOWN_EN adds the iDown signal.
interface decimal_counter_core_if #(
   parameter int unsigned NUM_DIGITS = 4
);
   logic                      iTickClk;
   logic                      iStart;
   logic                      iStop;
   logic                      iClear;
`ifdef DECIMAL_COUNTER_DOWN_EN
   logic                      iDown;
`endif
   logic [4*NUM_DIGITS-1:0]   oDigits;
   logic                      oRunning;
   logic                      oWrap;

`ifdef DECIMAL_COUNTER_DOWN_EN
   modport master (
      output iTickClk, iStart, iStop, iClear, iDown,
      input  oDigits, oRunning, oWrap
   );
   modport slave (
      input  iTickClk, iStart, iStop, iClear, iDown,
      output oDigits, oRunning, oWrap
   );
`else
   modport master (
      output iTickClk, iStart, iStop, iClear,
      input  oDigits, oRunning, oWrap
   );
   modport slave (
      input  iTickClk, iStart, iStop, iClear,
      output oDigits, oRunning, oWrap
   );
`endif

endinterface

// File: rtl/decimal_counter_core_bcd_digit.sv
// One BCD digit of the counter; oCarry flags the digit about to roll over in the current direction.
module bcd_digit
   import decimal_counter_pkg::*;
(
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iClear,
   input  logic             iEn,
   input  logic             iDown,
   output logic [BCD_W-1:0] oVal,
   output logic             oCarry
);

   always_ff @(posedge iClk) begin
      if (iRst)
         oVal <= '0;
      else if (iClear)
         oVal <= '0;
      else if (iEn)
         oVal <= bcdStep(oVal, iDown);
   end

   assign oCarry = iDown ? (oVal == '0) : (oVal == BCD_MAX);

endmodule

// File: rtl/decimal_counter_core.sv
// Multi-digit BCD counter advanced by rising edges of a slow divided clock.
// Optional build macro: DECIMAL_COUNTER_DOWN_EN enables iDown (tick decrements).
module decimal_counter_core
   import decimal_counter_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  iClk,
   input  logic                  iRst,
   decimal_counter_core_if.slave bus
);

   logic [SYNC_STAGES-1:0] syncQ;
   logic                   delayQ;
   logic                   tick;
   state_t                 state;
   logic                   down;
   logic [NUM_DIGITS:0]    en;
   logic [NUM_DIGITS-1:0]  carry;
   logic                   wrapQ;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         syncQ  <= '0;
         delayQ <= 1'b0;
      end else begin
         syncQ[0] <= bus.iTickClk;
         for (int unsigned i = 1; i < SYNC_STAGES; i++)
            syncQ[i] <= syncQ[i-1];
         delayQ <= syncQ[SYNC_STAGES-1];
      end
   end

   assign tick = syncQ[SYNC_STAGES-1] & ~delayQ;

   // Stop has priority when both requests arrive together.
   always_ff @(posedge iClk) begin
      if (iRst)
         state <= ST_STOP;
      else begin
         case (state)
            ST_STOP: if (bus.iStart && !bus.iStop) state <= ST_RUN;
            ST_RUN:  if (bus.iStop) state <= ST_STOP;
            default: state <= ST_STOP;
         endcase
      end
   end

`ifdef DECIMAL_COUNTER_DOWN_EN
   assign down = bus.iDown;
`else
   assign down = 1'b0;
`endif

   assign en[0] = tick & (state == ST_RUN);

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDigit
      bcd_digit uDigit (
         .iClk   (iClk),
         .iRst   (iRst),
         .iClear (bus.iClear),
         .iEn    (en[g]),
         .iDown  (down),
         .oVal   (bus.oDigits[g*BCD_W +: BCD_W]),
         .oCarry (carry[g])
      );
      assign en[g+1] = en[g] & carry[g];
   end

   // Enable rippling out of the top digit means every digit rolled over.
   always_ff @(posedge iClk) begin
      if (iRst)
         wrapQ <= 1'b0;
      else
         wrapQ <= en[NUM_DIGITS] & ~bus.iClear;
   end

   assign bus.oRunning = (state == ST_RUN);
   assign bus.oWrap    = wrapQ;

endmodule

// File: tb/tb_decimal_counter_core.sv
// Self-checking bench for decimal_counter_core against an integer-count reference model.
// Build with DECIMAL_COUNTER_DOWN_EN defined to also cover down-counting.
module tb_decimal_counter_core;

   localparam int MODULUS = 10000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   mCnt = 0;
   bit   mRun = 1'b0;

   decimal_counter_core_if #(.NUM_DIGITS(4)) bus ();

   decimal_counter_core #(.NUM_DIGITS(4), .SYNC_STAGES(2)) dut (
      .iClk (clk),
      .iRst (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] toBcd(input int v);
      logic [15:0] r;
      int x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Fast tick train (1 high, 1 low), then drain the sync pipe; counts observed wrap pulses.
   task automatic fastTicks(input int n, output int wraps);
      wraps = 0;
      repeat (n) begin
         bus.iTickClk = 1'b1;
         cyc(1);
         wraps += int'(bus.oWrap);
         bus.iTickClk = 1'b0;
         cyc(1);
         wraps += int'(bus.oWrap);
      end
      repeat (3) begin
         cyc(1);
         wraps += int'(bus.oWrap);
      end
   endtask

   // Reference: count advances by n modulo 10^4 while running; returns expected wrap count.
   function automatic int modelTicks(input int n, input bit dn);
      int w;
      w = 0;
      if (mRun) begin
         if (!dn) begin
            w = (mCnt + n) / MODULUS;
            mCnt = (mCnt + n) % MODULUS;
         end else begin
            if (n > mCnt) w = (n - mCnt - 1) / MODULUS + 1;
            mCnt = ((mCnt - n) % MODULUS + MODULUS) % MODULUS;
         end
      end
      return w;
   endfunction

   task automatic test_reset;
      rst = 1'b1;
      cyc(3);
      total++;
      if (bus.oDigits !== 16'h0000) begin bad++; $display("FAIL reset_digits: got %h expected 0000", bus.oDigits); end
      total++;
      if (bus.oRunning !== 1'b0) begin bad++; $display("FAIL reset_running: got %b expected 0", bus.oRunning); end
      total++;
      if (bus.oWrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b expected 0", bus.oWrap); end
      rst = 1'b0;
      cyc(1);
      mCnt = 0;
      mRun = 1'b0;
   endtask

   task automatic test_count;
      logic [15:0] exp;
      bus.iStart = 1'b1;
      cyc(1);
      bus.iStart = 1'b0;
      mRun = 1'b1;
      total++;
      if (bus.oRunning !== 1'b1) begin bad++; $display("FAIL start_running: got %b expected 1", bus.oRunning); end
      for (int t = 1; t <= 12; t++) begin
         bus.iTickClk = 1'b1;
         for (int k = 1; k <= 5; k++) begin
            cyc(1);
            exp = toBcd((k >= 3) ? t : t - 1);
            total++;
            if (bus.oDigits !== exp) begin bad++; $display("FAIL count_latency t=%0d k=%0d: got %h expected %h", t, k, bus.oDigits, exp); end
         end
         bus.iTickClk = 1'b0;
         cyc(5);
      end
      void'(modelTicks(12, 1'b0));
      total++;
      if (bus.oDigits !== 16'h0012 || bus.oRunning !== 1'b1) begin
         bad++; $display("FAIL count_12: got %h run=%b expected 0012 run=1", bus.oDigits, bus.oRunning);
      end
   endtask

   task automatic test_stop_start;
      int w;
      fastTicks(40 - mCnt, w);
      void'(modelTicks(40 - mCnt, 1'b0));
      total++;
      if (bus.oDigits !== toBcd(40)) begin bad++; $display("FAIL preload_40: got %h expected 0040", bus.oDigits); end
      // Stop coincident with the tick: the tick still counts.
      bus.iTickClk = 1'b1;
      cyc(2);
      bus.iStop = 1'b1;
      cyc(1);
      bus.iStop = 1'b0;
      mCnt = 41;
      mRun = 1'b0;
      total++;
      if (bus.oDigits !== 16'h0041 || bus.oRunning !== 1'b0) begin
         bad++; $display("FAIL stop_with_tick: got %h run=%b expected 0041 run=0", bus.oDigits, bus.oRunning);
      end
      bus.iTickClk = 1'b0;
      cyc(3);
      fastTicks(5, w);
      total++;
      if (bus.oDigits !== 16'h0041) begin bad++; $display("FAIL stopped_hold: got %h expected 0041", bus.oDigits); end
      bus.iStart = 1'b1;
      bus.iStop = 1'b1;
      cyc(1);
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
      total++;
      if (bus.oRunning !== 1'b0) begin bad++; $display("FAIL stop_wins: got %b expected 0", bus.oRunning); end
      bus.iStart = 1'b1;
      cyc(1);
      bus.iStart = 1'b0;
      mRun = 1'b1;
      fastTicks(1, w);
      void'(modelTicks(1, 1'b0));
      total++;
      if (bus.oDigits !== 16'h0042 || bus.oRunning !== 1'b1) begin
         bad++; $display("FAIL restart_42: got %h run=%b expected 0042 run=1", bus.oDigits, bus.oRunning);
      end
   endtask

   task automatic test_clear;
      int w;
      fastTicks(999 - mCnt, w);
      void'(modelTicks(999 - mCnt, 1'b0));
      total++;
      if (bus.oDigits !== 16'h0999) begin bad++; $display("FAIL preload_999: got %h expected 0999", bus.oDigits); end
      bus.iTickClk = 1'b1;
      cyc(2);
      bus.iClear = 1'b1;
      cyc(1);
      bus.iClear = 1'b0;
      total++;
      if (bus.oDigits !== 16'h0000 || bus.oWrap !== 1'b0 || bus.oRunning !== 1'b1) begin
         bad++; $display("FAIL clear_with_tick: got %h wrap=%b run=%b expected 0000 wrap=0 run=1", bus.oDigits, bus.oWrap, bus.oRunning);
      end
      bus.iTickClk = 1'b0;
      cyc(4);
      total++;
      if (bus.oDigits !== 16'h0000) begin bad++; $display("FAIL clear_tick_dropped: got %h expected 0000", bus.oDigits); end
      mCnt = 0;
   endtask

   task automatic test_wrap;
      int w;
      logic [15:0] exp;
      fastTicks(9998 - mCnt, w);
      void'(modelTicks(9998 - mCnt, 1'b0));
      total++;
      if (bus.oDigits !== 16'h9998 || w != 0) begin
         bad++; $display("FAIL preload_9998: got %h wraps=%0d expected 9998 wraps=0", bus.oDigits, w);
      end
      for (int t = 0; t < 2; t++) begin
         bus.iTickClk = 1'b1;
         for (int k = 1; k <= 6; k++) begin
            cyc(1);
            exp = (t == 0) ? ((k >= 3) ? 16'h9999 : 16'h9998) : ((k >= 3) ? 16'h0000 : 16'h9999);
            total++;
            if (bus.oDigits !== exp) begin bad++; $display("FAIL wrap_digits t=%0d k=%0d: got %h expected %h", t, k, bus.oDigits, exp); end
            total++;
            if (bus.oWrap !== ((t == 1) && (k == 3))) begin
               bad++; $display("FAIL wrap_pulse t=%0d k=%0d: got %b expected %b", t, k, bus.oWrap, (t == 1) && (k == 3));
            end
         end
         bus.iTickClk = 1'b0;
         cyc(4);
      end
      mCnt = 0;
   endtask

   task automatic test_reset_mid;
      int w;
      fastTicks(7 - mCnt, w);
      void'(modelTicks(7 - mCnt, 1'b0));
      total++;
      if (bus.oDigits !== 16'h0007) begin bad++; $display("FAIL preload_7: got %h expected 0007", bus.oDigits); end
      bus.iTickClk = 1'b1;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      total++;
      if (bus.oDigits !== 16'h0000 || bus.oRunning !== 1'b0 || bus.oWrap !== 1'b0) begin
         bad++; $display("FAIL reset_mid: got %h run=%b wrap=%b expected 0000 run=0 wrap=0", bus.oDigits, bus.oRunning, bus.oWrap);
      end
      for (int k = 0; k < 6; k++) begin
         cyc(1);
         total++;
         if (bus.oDigits !== 16'h0000) begin bad++; $display("FAIL reset_no_incr k=%0d: got %h expected 0000", k, bus.oDigits); end
      end
      bus.iTickClk = 1'b0;
      cyc(3);
      mCnt = 0;
      mRun = 1'b0;
   endtask

`ifdef DECIMAL_COUNTER_DOWN_EN
   task automatic test_down;
      int w;
      logic [15:0] exp;
      bus.iStart = 1'b1;
      cyc(1);
      bus.iStart = 1'b0;
      mRun = 1'b1;
      fastTicks(1, w);
      void'(modelTicks(1, 1'b0));
      bus.iDown = 1'b1;
      fastTicks(1, w);
      void'(modelTicks(1, 1'b1));
      total++;
      if (bus.oDigits !== 16'h0000 || w != 0) begin
         bad++; $display("FAIL down_to_0: got %h wraps=%0d expected 0000 wraps=0", bus.oDigits, w);
      end
      bus.iTickClk = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         cyc(1);
         exp = (k >= 3) ? 16'h9999 : 16'h0000;
         total++;
         if (bus.oDigits !== exp || bus.oWrap !== (k == 3)) begin
            bad++; $display("FAIL down_wrap k=%0d: got %h wrap=%b expected %h wrap=%b", k, bus.oDigits, bus.oWrap, exp, k == 3);
         end
      end
      bus.iTickClk = 1'b0;
      bus.iDown = 1'b0;
      cyc(4);
      mCnt = 9999;
   endtask
`endif

   task automatic test_random;
      int op, n, w, ew;
      bit dn;
      for (int it = 0; it < 200; it++) begin
         op = int'($urandom_range(0, 7));
         case (op)
            0: begin bus.iStart = 1'b1; cyc(1); bus.iStart = 1'b0; mRun = 1'b1; end
            1: begin bus.iStop = 1'b1; cyc(1); bus.iStop = 1'b0; mRun = 1'b0; end
            2: begin bus.iStart = 1'b1; bus.iStop = 1'b1; cyc(1); bus.iStart = 1'b0; bus.iStop = 1'b0; mRun = 1'b0; end
            3: begin bus.iClear = 1'b1; cyc(1); bus.iClear = 1'b0; mCnt = 0; end
            default: begin
               n = int'($urandom_range(1, 30));
               dn = 1'b0;
`ifdef DECIMAL_COUNTER_DOWN_EN
               dn = 1'($urandom_range(0, 1));
               bus.iDown = dn;
`endif
               fastTicks(n, w);
               ew = modelTicks(n, dn);
               total++;
               if (w != ew) begin bad++; $display("FAIL rand_wraps it=%0d: got %0d expected %0d", it, w, ew); end
            end
         endcase
         cyc(1);
         total++;
         if (bus.oDigits !== toBcd(mCnt) || bus.oRunning !== mRun) begin
            bad++; $display("FAIL rand_state it=%0d: got %h run=%b expected %h run=%b", it, bus.oDigits, bus.oRunning, toBcd(mCnt), mRun);
         end
      end
   endtask

   initial begin
      bus.iTickClk = 1'b0;
      bus.iStart = 1'b0;
      bus.iStop = 1'b0;
      bus.iClear = 1'b0;
`ifdef DECIMAL_COUNTER_DOWN_EN
      bus.iDown = 1'b0;
`endif
      cyc(2);
      test_reset;
      test_count;
      test_stop_start;
      test_clear;
      test_wrap;
      test_reset_mid;
`ifdef DECIMAL_COUNTER_DOWN_EN
      test_down;
`endif
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
